// File: rtl/pwm_gen_3ph.sv
// rtl/pwm_gen_3ph.sv - three-phase centre-aligned PWM with double-buffered duties; define DEADTIME_EN for dead-time insertion
module pwm_gen_3ph #(
    parameter int D_WIDTH  = 19,
    parameter int DT_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rstb,
    input  logic                valid,
    output logic                ready,
    input  logic [D_WIDTH-1:0]  dutyA_in,
    input  logic [D_WIDTH-1:0]  dutyB_in,
    input  logic [D_WIDTH-1:0]  dutyC_in,
    input  logic [D_WIDTH-1:0]  periodTop,
    input  logic [DT_WIDTH-1:0] deadtime_in,
    output logic                pwmA_out,
    output logic                pwmA_n_out,
    output logic                pwmB_out,
    output logic                pwmB_n_out,
    output logic                pwmC_out,
    output logic                pwmC_n_out,
    output logic                period_start
);

    typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

    dir_t                      dir, dir_nxt;
    logic [D_WIDTH-1:0]        cnt, cnt_nxt;
    logic [D_WIDTH-1:0]        period_act, p_eff;
    logic [2:0][D_WIDTH-1:0]   duty_in, duty_pend, duty_act, duty_eff;
    logic                      pend_full, pend_full_nxt;
    logic                      valley, en, accept, load;
    logic [2:0]                raw;
    logic [2:0]                hs, ls;

    // The period being entered at a valley uses the live periodTop, so the
    // enable decision, clamp and first compare all see the newly latched value.
    always_comb begin
        duty_in       = {dutyC_in, dutyB_in, dutyA_in};
        valley        = (cnt == '0);
        p_eff         = valley ? periodTop : period_act;
        en            = (p_eff >= D_WIDTH'(2));
        accept        = valid && ready;
        load          = valley && pend_full;
        pend_full_nxt = pend_full;
        if (load)
            pend_full_nxt = 1'b0;
        if (accept)
            pend_full_nxt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            duty_eff[i] = duty_act[i];
            if (load)
                duty_eff[i] = (duty_pend[i] > p_eff) ? p_eff : duty_pend[i];
            // Falling half compares one count later so the pulse is exactly 2*duty cycles.
            raw[i] = en && ((duty_eff[i] == p_eff) || (cnt < duty_eff[i]) ||
                            (dir == DIR_DOWN && cnt == duty_eff[i] && duty_eff[i] != '0));
        end
        cnt_nxt = '0;
        dir_nxt = DIR_UP;
        if (en) begin
            if (valley) begin
                cnt_nxt = D_WIDTH'(1);
                dir_nxt = DIR_UP;
            end else if (dir == DIR_UP) begin
                if (cnt >= p_eff) begin
                    cnt_nxt = cnt - D_WIDTH'(1);
                    dir_nxt = DIR_DOWN;
                end else begin
                    cnt_nxt = cnt + D_WIDTH'(1);
                    dir_nxt = DIR_UP;
                end
            end else begin
                cnt_nxt = cnt - D_WIDTH'(1);
                dir_nxt = DIR_DOWN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rstb) begin
            cnt          <= '0;
            dir          <= DIR_UP;
            period_act   <= '0;
            duty_pend    <= '0;
            duty_act     <= '0;
            pend_full    <= 1'b0;
            ready        <= 1'b0;
            period_start <= 1'b0;
        end else begin
            cnt          <= cnt_nxt;
            dir          <= dir_nxt;
            if (valley)
                period_act <= periodTop;
            if (accept)
                duty_pend <= duty_in;
            duty_act     <= duty_eff;
            pend_full    <= pend_full_nxt;
            ready        <= !pend_full_nxt;
            period_start <= valley && en;
        end
    end

`ifdef DEADTIME_EN
    logic [2:0]               raw_q;
    logic [2:0][DT_WIDTH-1:0] dt_cnt;

    // Any raw edge blanks both gates for deadtime_in cycles; a new edge restarts the blanking.
    always_ff @(posedge clk) begin
        if (rstb) begin
            raw_q  <= '0;
            dt_cnt <= '0;
            hs     <= '0;
            ls     <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                raw_q[i] <= raw[i];
                if (!en) begin
                    hs[i]     <= 1'b0;
                    ls[i]     <= 1'b0;
                    dt_cnt[i] <= '0;
                end else if (deadtime_in == '0) begin
                    hs[i]     <= raw[i];
                    ls[i]     <= !raw[i];
                    dt_cnt[i] <= '0;
                end else if (raw[i] != raw_q[i]) begin
                    hs[i]     <= 1'b0;
                    ls[i]     <= 1'b0;
                    dt_cnt[i] <= deadtime_in - DT_WIDTH'(1);
                end else if (dt_cnt[i] != '0) begin
                    hs[i]     <= 1'b0;
                    ls[i]     <= 1'b0;
                    dt_cnt[i] <= dt_cnt[i] - DT_WIDTH'(1);
                end else begin
                    hs[i]     <= raw[i];
                    ls[i]     <= !raw[i];
                end
            end
        end
    end
`else
    logic dt_unused;
    assign dt_unused = ^deadtime_in;

    always_ff @(posedge clk) begin
        if (rstb) begin
            hs <= '0;
            ls <= '0;
        end else begin
            hs <= raw;
            ls <= {3{en}} & ~raw;
        end
    end
`endif

    assign pwmA_out   = hs[0];
    assign pwmA_n_out = ls[0];
    assign pwmB_out   = hs[1];
    assign pwmB_n_out = ls[1];
    assign pwmC_out   = hs[2];
    assign pwmC_n_out = ls[2];

endmodule

// File: tb/tb_pwm_gen_3ph.sv
// tb/tb_pwm_gen_3ph.sv - scoreboard bench for pwm_gen_3ph, per-period gate on-time checks
module tb_pwm_gen_3ph;
    localparam int DW = 19;
    localparam int TW = 8;
    localparam int P  = 100;
`ifdef DEADTIME_EN
    localparam int DT = 5;
`else
    localparam int DT = 0;
`endif

    logic          clk, rstb, valid, ready;
    logic [DW-1:0] dutyA_in, dutyB_in, dutyC_in, periodTop;
    logic [TW-1:0] deadtime_in;
    logic          pwmA_out, pwmA_n_out, pwmB_out, pwmB_n_out, pwmC_out, pwmC_n_out;
    logic          period_start;

    pwm_gen_3ph #(.D_WIDTH(DW), .DT_WIDTH(TW)) dut (
        .clk(clk), .rstb(rstb), .valid(valid), .ready(ready),
        .dutyA_in(dutyA_in), .dutyB_in(dutyB_in), .dutyC_in(dutyC_in),
        .periodTop(periodTop), .deadtime_in(deadtime_in),
        .pwmA_out(pwmA_out), .pwmA_n_out(pwmA_n_out),
        .pwmB_out(pwmB_out), .pwmB_n_out(pwmB_n_out),
        .pwmC_out(pwmC_out), .pwmC_n_out(pwmC_n_out),
        .period_start(period_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        int               idx;
        logic             chk;
        logic [2:0][31:0] hi;
        logic [2:0][31:0] lo;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   mon_win  = -1;
    int   len, ov;
    int   hc[3];
    int   lc[3];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int clampd(input int d);
        return (d > P) ? P : d;
    endfunction

    // Expected window of 2P cycles: on-time 2*d, minus blanking for each edge that lands in it.
    task automatic push(input int idx, input bit c, input int a, input int b, input int cc,
                        input int pa, input int pb, input int pc);
        exp_t e;
        int d[3];
        int dp[3];
        int r, f;
        d[0] = clampd(a);   d[1] = clampd(b);   d[2] = clampd(cc);
        dp[0] = clampd(pa); dp[1] = clampd(pb); dp[2] = clampd(pc);
        e.idx = idx;
        e.chk = c;
        for (int i = 0; i < 3; i++) begin
            r = 0;
            f = 0;
            if (d[i] > 0 && d[i] < P) begin r++; f++; end
            if (dp[i] == 0 && d[i] > 0) r++;
            if (dp[i] > 0 && d[i] == 0) f++;
            e.hi[i] = 32'(2 * d[i] - DT * r);
            e.lo[i] = 32'(2 * P - 2 * d[i] - DT * f);
        end
        q.push_back(e);
    endtask

    task automatic close_win();
        exp_t e;
        if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL win%0d_expect actual=none required=record", mon_win);
        end else begin
            e = q.pop_front();
            chk($sformatf("win%0d_index", mon_win), mon_win, e.idx);
            if (e.chk && e.idx == mon_win) begin
                chk($sformatf("win%0d_len", mon_win), len, 2 * P);
                chk($sformatf("win%0d_overlap", mon_win), ov, 0);
                for (int i = 0; i < 3; i++) begin
                    chk($sformatf("win%0d_ph%0d_high", mon_win, i), hc[i], int'(e.hi[i]));
                    chk($sformatf("win%0d_ph%0d_low", mon_win, i), lc[i], int'(e.lo[i]));
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (period_start) begin
                if (mon_win >= 0)
                    close_win();
                mon_win++;
                len = 0;
                ov  = 0;
                for (int i = 0; i < 3; i++) begin hc[i] = 0; lc[i] = 0; end
            end
            len++;
            hc[0] += int'(pwmA_out); lc[0] += int'(pwmA_n_out);
            hc[1] += int'(pwmB_out); lc[1] += int'(pwmB_n_out);
            hc[2] += int'(pwmC_out); lc[2] += int'(pwmC_n_out);
            if ((pwmA_out && pwmA_n_out) || (pwmB_out && pwmB_n_out) || (pwmC_out && pwmC_n_out))
                ov++;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_win(input int n);
        int t = 0;
        while (mon_win < n && t < 1000) begin
            step(1);
            t++;
        end
        chk($sformatf("wait_win%0d", n), int'(mon_win >= n), 1);
    endtask

    task automatic send(input int a, input int b, input int c);
        int t = 0;
        valid    = 1'b1;
        dutyA_in = DW'(a);
        dutyB_in = DW'(b);
        dutyC_in = DW'(c);
        while (!ready && t < 1000) begin
            step(1);
            t++;
        end
        if (!ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=ready0 required=ready1");
            valid = 1'b0;
        end else begin
            step(1);
            valid = 1'b0;
            chk("ready_drop", int'(ready), 0);
        end
    endtask

    function automatic int gates();
        return int'({pwmA_out, pwmA_n_out, pwmB_out, pwmB_n_out, pwmC_out, pwmC_n_out} != 6'b0);
    endfunction

    initial begin
        int bad;
        rstb = 1'b1; valid = 1'b0;
        dutyA_in = '0; dutyB_in = '0; dutyC_in = '0;
        periodTop = DW'(P); deadtime_in = TW'(5);
        push(0, 1'b1, 0, 0, 0, 0, 0, 0);
        push(1, 1'b1, 0, 0, 0, 0, 0, 0);
        step(3);
        chk("reset_ready", int'(ready), 0);
        chk("reset_gates", gates(), 0);
        chk("reset_period_start", int'(period_start), 0);
        rstb = 1'b0;
        step(1);
        chk("ready_after_reset", int'(ready), 1);

        wait_win(1);
        step(20);
        push(2, 1'b1, 50, 25, 75, 0, 0, 0);
        send(50, 25, 75);
        wait_win(2);
        chk("ready_back_after_valley", int'(ready), 1);

        step(10);
        push(3, 1'b1, 150, 0, 100, 50, 25, 75);
        send(150, 0, 100);
        step(5);
        chk("held_off", int'(ready), 0);
        push(4, 1'b1, 0, 100, 10, 150, 0, 100);
        push(5, 1'b1, 0, 100, 10, 0, 100, 10);
        send(0, 100, 10);
        chk("b2b_capture_win", mon_win, 3);

        wait_win(6);
        push(6, 1'b0, 0, 0, 0, 0, 0, 0);
        step(10);
        periodTop = DW'(1);
        step(2 * P + 20);
        bad = 0;
        repeat (20) begin
            if (gates() != 0 || period_start) bad++;
            step(1);
        end
        chk("disabled_quiet", bad, 0);
        push(7, 1'b1, 0, 0, 0, 0, 0, 0);
        send(0, 0, 0);
        step(1);
        chk("disabled_reload", int'(ready), 1);
        periodTop = DW'(P);
        wait_win(7);

        wait_win(8);
        push(8, 1'b0, 0, 0, 0, 0, 0, 0);
        step(30);
        send(60, 60, 60);
        step(20);
        rstb = 1'b1;
        step(1);
        chk("midreset_gates", gates(), 0);
        chk("midreset_ready", int'(ready), 0);
        chk("midreset_period_start", int'(period_start), 0);
        step(1);
        rstb = 1'b0;
        step(1);
        chk("ready_after_midreset", int'(ready), 1);
        push(9, 1'b1, 0, 0, 0, 0, 0, 0);
        push(10, 1'b1, 0, 0, 0, 0, 0, 0);

        wait_win(10);
        step(20);
        push(11, 1'b1, 90, 30, 50, 0, 0, 0);
        push(12, 1'b1, 90, 30, 50, 90, 30, 50);
        send(90, 30, 50);
        wait_win(13);
        chk("queue_drained", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
